// File: rtl/pr_ar_scheduler.sv
// Arbitrates the DDR AR channel between demand and prefetch requesters, tracks
// outstanding bursts from R-channel last beats and runs the stop/drain/resume flush.
module pr_ar_scheduler #(
  parameter int ADDR_BITS         = 16,
  parameter int TID_WIDTH         = 8,
  parameter int BURST_LEN_WIDTH   = 8,
  parameter int LOG_QUEUE_SIZE    = 3,
  parameter int PRFETCH_FRQ_WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         en,
  input  logic                         dm_ar_valid,
  output logic                         dm_ar_ready,
  input  logic [ADDR_BITS-1:0]         dm_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0]   dm_ar_len,
  input  logic [TID_WIDTH-1:0]         dm_ar_id,
  input  logic                         pf_ar_valid,
  output logic                         pf_ar_ready,
  input  logic [ADDR_BITS-1:0]         pf_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0]   pf_ar_len,
  input  logic [TID_WIDTH-1:0]         pf_ar_id,
  output logic                         m_ar_valid,
  input  logic                         m_ar_ready,
  output logic [ADDR_BITS-1:0]         m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0]   m_ar_len,
  output logic [TID_WIDTH-1:0]         m_ar_id,
  output logic                         m_ar_isPrefetch,
  input  logic                         m_r_valid,
  input  logic                         m_r_ready,
  input  logic                         m_r_last,
  input  logic [LOG_QUEUE_SIZE:0]      crs_prOutstandingLimit,
  input  logic [PRFETCH_FRQ_WIDTH-1:0] crs_prBandwidthThrottle,
  input  logic                         flushReq,
  output logic                         flushDone,
  output logic [LOG_QUEUE_SIZE:0]      outstandingCnt,
  output logic                         errUnderflow
);

  localparam int CNT_W = LOG_QUEUE_SIZE + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PRFETCH_FRQ_WIDTH-1:0] THR_ONE = PRFETCH_FRQ_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_BITS-1:0]         addr_q, addr_d;
  logic [BURST_LEN_WIDTH-1:0]   len_q, len_d;
  logic [TID_WIDTH-1:0]         id_q, id_d;
  logic                         is_pf_q, is_pf_d;
  logic [PRFETCH_FRQ_WIDTH-1:0] thr_q, thr_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         err_q, err_d;
  logic                         flush_done_q, flush_done_d;

  logic dm_grant;
  logic pf_grant;
  logic ar_hs;
  logic r_last_hs;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_ARB;
    end else begin
      state_q <= state_d;
    end
  end

  // A flush request takes priority over a grant in ARB; HOLD always finishes its beat first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB: begin
        if (flushReq) begin
          state_d = ST_FLUSH;
        end else if (dm_grant || pf_grant) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (m_ar_ready) begin
          state_d = flushReq ? ST_FLUSH : ST_ARB;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_comb begin
    m_ar_valid   = (state_q == ST_HOLD);
    dm_ar_ready  = en && (state_q == ST_ARB) && !flushReq && (cnt_q != CNT_MAX);
    pf_ar_ready  = en && (state_q == ST_ARB) && !flushReq && !dm_ar_valid &&
                   (thr_q == '0) && (cnt_q < crs_prOutstandingLimit);
    flush_done_d = (state_q == ST_FLUSH) && (cnt_q == '0);
  end

  assign dm_grant  = dm_ar_valid && dm_ar_ready;
  assign pf_grant  = pf_ar_valid && pf_ar_ready;
  assign ar_hs     = m_ar_valid && m_ar_ready;
  assign r_last_hs = m_r_valid && m_r_ready && m_r_last;

  always_comb begin
    addr_d  = addr_q;
    len_d   = len_q;
    id_d    = id_q;
    is_pf_d = is_pf_q;
    if (dm_grant) begin
      addr_d  = dm_ar_addr;
      len_d   = dm_ar_len;
      id_d    = dm_ar_id;
      is_pf_d = 1'b0;
    end else if (pf_grant) begin
      addr_d  = pf_ar_addr;
      len_d   = pf_ar_len;
      id_d    = pf_ar_id;
      is_pf_d = 1'b1;
    end
  end

  // Only prefetch grants reload the throttle; demand traffic never waits on it.
  always_comb begin
    thr_d = thr_q;
    if (pf_grant) begin
      thr_d = crs_prBandwidthThrottle;
    end else if (thr_q != '0) begin
      thr_d = thr_q - THR_ONE;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    case ({ar_hs, r_last_hs})
      2'b10: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      2'b01: begin
        if (cnt_q == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      addr_q       <= '0;
      len_q        <= '0;
      id_q         <= '0;
      is_pf_q      <= 1'b0;
      thr_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      len_q        <= len_d;
      id_q         <= id_d;
      is_pf_q      <= is_pf_d;
      thr_q        <= thr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign m_ar_addr       = addr_q;
  assign m_ar_len        = len_q;
  assign m_ar_id         = id_q;
  assign m_ar_isPrefetch = is_pf_q;
  assign outstandingCnt  = cnt_q;
  assign errUnderflow    = err_q;
  assign flushDone       = flush_done_q;

endmodule
